multicycle_ctrl: RTL and testbench

//  Multi-cycle control unit for the 3-bit-opcode teaching CPU. Sequences each instruction through

---
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl - FETCH/DECODE/EXEC/MEM/WB control sequencer for the 3-bit-opcode teaching CPU
module multicycle_ctrl #(
  parameter int OP_W    = 3,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               RegDst_o,
  output logic               Branch_o,
  output logic               BranchType_o,
  output logic               MemToReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               Jump_o,
  output logic               illegal_o,
  output logic [2:0]         state_o,
  output logic [CNT_W-1:0]   retired_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SLTI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_BNE  = 3'b110;

  state_t            state, nextState;
  logic [OP_W-1:0]   opQ;
  logic [CNT_W-1:0]  retiredQ;
  logic [2:0]        opc;
  logic              isIllegal;

  assign opc = opQ[2:0];

  // Any opcode bit above bit 2 marks the instruction illegal.
  generate
    if (OP_W > 3) begin : gIllegal
      assign isIllegal = |opQ[OP_W-1:3];
    end else begin : gNoIllegal
      assign isIllegal = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      opQ      <= '0;
      retiredQ <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH && instr_valid_i) opQ <= instr_op_i;
      // pc_write_o marks the final cycle of every legal instruction.
      if (pc_write_o) retiredQ <= retiredQ + 1'b1;
    end
  end

  always_comb begin
    nextState     = state;
    instr_ready_o = 1'b0;
    pc_write_o    = 1'b0;
    RegWrite_o    = 1'b0;
    ALUOp_o       = '0;
    ALUSrc_o      = 1'b0;
    RegDst_o      = 1'b0;
    Branch_o      = 1'b0;
    BranchType_o  = 1'b0;
    MemToReg_o    = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    Jump_o        = 1'b0;
    illegal_o     = 1'b0;
    case (state)
      FETCH: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) nextState = DECODE;
      end
      DECODE: begin
        if (isIllegal) begin
          illegal_o = 1'b1;
          nextState = FETCH;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        case (opc)
          OP_R: begin
            ALUOp_o   = ALUOP_W'(2'b10);
            nextState = WB;
          end
          OP_ADDI: begin
            ALUSrc_o  = 1'b1;
            nextState = WB;
          end
          OP_SLTI: begin
            ALUOp_o   = ALUOP_W'(2'b11);
            ALUSrc_o  = 1'b1;
            nextState = WB;
          end
          OP_LW, OP_SW: begin
            ALUSrc_o  = 1'b1;
            nextState = MEM;
          end
          OP_BEQ, OP_BNE: begin
            ALUOp_o      = ALUOP_W'(2'b01);
            Branch_o     = 1'b1;
            BranchType_o = opc[1];
            pc_write_o   = 1'b1;
            nextState    = FETCH;
          end
          default: begin
            Jump_o     = 1'b1;
            pc_write_o = 1'b1;
            nextState  = FETCH;
          end
        endcase
      end
      MEM: begin
        ALUSrc_o   = 1'b1;
        MemRead_o  = (opc == OP_LW);
        MemWrite_o = (opc == OP_SW);
        if (mem_ready_i) begin
          if (opc == OP_SW) begin
            pc_write_o = 1'b1;
            nextState  = FETCH;
          end else begin
            nextState = WB;
          end
        end
      end
      WB: begin
        RegWrite_o = 1'b1;
        pc_write_o = 1'b1;
        RegDst_o   = (opc == OP_R);
        MemToReg_o = (opc == OP_LW);
        nextState  = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  assign state_o   = state;
  assign retired_o = retiredQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [2:0]  op;
  logic        valid, memReady;
  logic        ready, pcWrite, regWrite, aluSrc, regDst, branch, branchType;
  logic        memToReg, memRead, memWrite, jump, illegal;
  logic [1:0]  aluOp;
  logic [2:0]  state;
  logic [15:0] retired;

  logic [3:0]  op4;
  logic        valid4, memReady4;
  logic        ready4, pcWrite4, regWrite4, aluSrc4, regDst4, branch4, branchType4;
  logic        memToReg4, memRead4, memWrite4, jump4, illegal4;
  logic [1:0]  aluOp4;
  logic [2:0]  state4;
  logic [3:0]  retired4;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rstN), .instr_op_i(op), .instr_valid_i(valid),
    .instr_ready_o(ready), .mem_ready_i(memReady), .pc_write_o(pcWrite),
    .RegWrite_o(regWrite), .ALUOp_o(aluOp), .ALUSrc_o(aluSrc), .RegDst_o(regDst),
    .Branch_o(branch), .BranchType_o(branchType), .MemToReg_o(memToReg),
    .MemRead_o(memRead), .MemWrite_o(memWrite), .Jump_o(jump),
    .illegal_o(illegal), .state_o(state), .retired_o(retired)
  );

  multicycle_ctrl #(.OP_W(4), .ALUOP_W(2), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rstN), .instr_op_i(op4), .instr_valid_i(valid4),
    .instr_ready_o(ready4), .mem_ready_i(memReady4), .pc_write_o(pcWrite4),
    .RegWrite_o(regWrite4), .ALUOp_o(aluOp4), .ALUSrc_o(aluSrc4), .RegDst_o(regDst4),
    .Branch_o(branch4), .BranchType_o(branchType4), .MemToReg_o(memToReg4),
    .MemRead_o(memRead4), .MemWrite_o(memWrite4), .Jump_o(jump4),
    .illegal_o(illegal4), .state_o(state4), .retired_o(retired4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; op = '0; valid = 1'b0; memReady = 1'b0;
    op4 = '0; valid4 = 1'b0; memReady4 = 1'b0;
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_ctrl", {pcWrite, regWrite, aluOp, aluSrc, memRead, memWrite, jump, illegal}, 0);
    tick();
    rstN = 1'b1;

    // R-type
    op = 3'b000; valid = 1'b1;
    chk("r_accept_ready", 32'(ready), 1);
    tick(); valid = 1'b0;
    chk("r_decode_state", 32'(state), 1);
    chk("r_decode_ready", 32'(ready), 0);
    tick();
    chk("r_exec_state", 32'(state), 2);
    chk("r_exec_aluop", 32'(aluOp), 2);
    chk("r_exec_alusrc", 32'(aluSrc), 0);
    chk("r_exec_regwrite", 32'(regWrite), 0);
    tick();
    chk("r_wb_state", 32'(state), 4);
    chk("r_wb_regwrite", 32'(regWrite), 1);
    chk("r_wb_regdst", 32'(regDst), 1);
    chk("r_wb_pcwrite", 32'(pcWrite), 1);
    chk("r_wb_memtoreg", 32'(memToReg), 0);
    tick();
    chk("r_done_state", 32'(state), 0);
    chk("r_done_retired", 32'(retired), 1);

    // lw with three wait cycles
    op = 3'b011; valid = 1'b1;
    tick(); valid = 1'b0;
    tick();
    chk("lw_exec_alusrc", 32'(aluSrc), 1);
    chk("lw_exec_memread", 32'(memRead), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      memReady = (i == 3);
      chk("lw_mem_state", 32'(state), 3);
      chk("lw_mem_memread", 32'(memRead), 1);
      chk("lw_mem_pcwrite", 32'(pcWrite), 0);
      tick();
    end
    memReady = 1'b1;
    chk("lw_wb_state", 32'(state), 4);
    chk("lw_wb_memtoreg", 32'(memToReg), 1);
    chk("lw_wb_regwrite", 32'(regWrite), 1);
    chk("lw_wb_regdst", 32'(regDst), 0);
    chk("lw_wb_memread", 32'(memRead), 0);
    tick(); memReady = 1'b0;
    chk("lw_done_state", 32'(state), 0);
    chk("lw_done_retired", 32'(retired), 2);

    // bne
    op = 3'b110; valid = 1'b1;
    tick(); valid = 1'b0;
    chk("bne_decode_regwrite", 32'(regWrite), 0);
    tick();
    chk("bne_exec_branch", 32'(branch), 1);
    chk("bne_exec_btype", 32'(branchType), 1);
    chk("bne_exec_aluop", 32'(aluOp), 1);
    chk("bne_exec_pcwrite", 32'(pcWrite), 1);
    chk("bne_exec_regwrite", 32'(regWrite), 0);
    tick();
    chk("bne_done_state", 32'(state), 0);
    chk("bne_done_retired", 32'(retired), 3);
    chk("bne_done_btype", 32'(branchType), 0);

    // sw interrupted by reset in MEM
    op = 3'b100; valid = 1'b1;
    tick(); valid = 1'b0;
    tick();
    tick();
    chk("sw_mem_state", 32'(state), 3);
    chk("sw_mem_memwrite", 32'(memWrite), 1);
    #2 rstN = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(memWrite), 0);
    chk("sw_rst_state", 32'(state), 0);
    chk("sw_rst_retired", 32'(retired), 0);
    chk("sw_rst_ready", 32'(ready), 1);
    tick();
    rstN = 1'b1;
    tick();
    chk("sw_after_regwrite", 32'(regWrite), 0);

    // illegal opcode on the 4-bit instance
    op4 = 4'b1011; valid4 = 1'b1;
    tick(); valid4 = 1'b0;
    chk("ill_decode_state", 32'(state4), 1);
    chk("ill_pulse", 32'(illegal4), 1);
    chk("ill_ctrl", {pcWrite4, regWrite4, aluOp4, aluSrc4, memRead4, memWrite4, jump4, branch4}, 0);
    tick();
    chk("ill_back_state", 32'(state4), 0);
    chk("ill_pulse_end", 32'(illegal4), 0);
    chk("ill_retired", 32'(retired4), 0);

    // 16 back-to-back jumps wrap the 4-bit counter
    op4 = 4'b0111; valid4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("j_retired_15", 32'(retired4), 15);
      chk("j_accept_ready", 32'(ready4), 1);
      tick();
      chk("j_decode_ready", 32'(ready4), 0);
      tick();
      chk("j_exec_jump", 32'(jump4), 1);
      chk("j_exec_pcwrite", 32'(pcWrite4), 1);
      tick();
    end
    valid4 = 1'b0;
    chk("j_wrap_retired", 32'(retired4), 0);
    chk("j_wrap_state", 32'(state4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
